// File: rtl/hazard_sequencer_pkg.sv
// rtl/hazard_sequencer_pkg.sv - shared pipeline hazard definitions
// Holds the sequencer state encoding, the E-stage forward-select codes and
// the forwarding priority function used by fwd_unit.
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    WAIT  = 2'b01,
    FAULT = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // The M-stage result is younger than the W-stage one, so it wins.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       we_m,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_M;
    if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - E-stage operand forwarding select
// Ports:
//   EN (param)            1 = forwarding active, 0 = selects tied to FWD_RF
//   Rs1E, Rs2E            E-stage source registers
//   RdM, RdW              destination registers of M and W
//   RegWriteM, RegWriteW  M/W write the register file
//   ForwardAE, ForwardBE  operand mux selects (FWD_RF / FWD_W / FWD_M)
module fwd_unit
  import hazard_sequencer_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  assign ForwardAE = EN ? fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW) : FWD_RF;
  assign ForwardBE = EN ? fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW) : FWD_RF;

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline hazard unit with data-memory wait sequencer
// Optional feature macro: HAZ_FORWARD_EN (operand forwarding; without it every
// RAW dependency on E or M stalls decode instead).
// Ports:
//   clk, reset (async, active low)
//   Rs1D/Rs2D/Rs1E/Rs2E/RdE/RdM/RdW   register specifiers per stage
//   RegWriteE/M/W                      stage writes the register file
//   ResultSrcE0                        E holds a load
//   PCSrcE                             branch taken / jump in E
//   MemReqM, MemReadyM                 data-memory handshake
//   StallF/D/E/M, FlushD/E/W           pipeline register controls
//   ForwardAE, ForwardBE               E operand mux selects
//   MemTimeout                         sticky memory-timeout fault
//   StallCount                         saturating count of stalled fetch cycles
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount
);

`ifdef HAZ_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam int WC_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int WC_W   = (WC_RAW > 8) ? WC_RAW : 8;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [WC_W-1:0] waitcnt;
  logic            memwait;
  logic            load_use, raw_e, raw_m, lduse;

  fwd_unit #(.EN(FWD_EN)) u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  assign memwait  = MemReqM & ~MemReadyM;
  assign load_use = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign raw_e    = RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign raw_m    = RegWriteM & (RdM != 5'd0) & ((RdM == Rs1D) | (RdM == Rs2D));
  // Without forwarding, any producer still in E or M must be waited out in D.
  assign lduse    = load_use | (~FWD_EN & (raw_e | raw_m));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      waitcnt    <= '0;
      MemTimeout <= 1'b0;
      StallCount <= '0;
    end else begin
      state <= state_nxt;
      // Held at zero outside WAIT, so it is already cleared on entry.
      if (state == WAIT) waitcnt <= waitcnt + WC_W'(1);
      else               waitcnt <= '0;
      if (state_nxt == FAULT) MemTimeout <= 1'b1;
      if (StallF && (StallCount != {CNT_W{1'b1}})) StallCount <= StallCount + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:   if (memwait) state_nxt = WAIT;
      WAIT: begin
        if (MemReadyM) state_nxt = RUN;
        else if (memwait && (waitcnt == WC_LAST)) state_nxt = FAULT;
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase
  end

  // Memory wait freezes the whole pipe and suppresses flushes; a branch in E
  // stays frozen with E and its flush lands once memwait drops. While reset
  // is held low nothing is requested at all.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      if (memwait || (state == FAULT)) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lduse;
        StallD = lduse;
        FlushD = PCSrcE;
        FlushE = lduse | PCSrcE;
      end
    end
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of data-memory wait cycles before a fault.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the stall-cycle counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, each input, 5 bits: register specifiers per stage.
REQ-006 SHALL have ports RegWriteE, RegWriteM, RegWriteW, each input, 1 bit: stage writes the register file.
REQ-007 SHALL have port ResultSrcE0, input, 1 bit: instruction in E is a load.
REQ-008 SHALL have port PCSrcE, input, 1 bit: branch taken or jump in E.
REQ-009 SHALL have ports MemReqM and MemReadyM, each input, 1 bit: data-memory request and ready handshake.
REQ-010 SHALL have ports StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, each output, 1 bit: pipeline register controls (FlushE drives the ID/EX clear).
REQ-011 SHALL have ports ForwardAE and ForwardBE, each output, 2 bits: E-stage operand mux selects.
REQ-012 SHALL have port MemTimeout, output, 1 bit: sticky memory-timeout fault.
REQ-013 SHALL have port StallCount, output, CNT_W bits: count of stalled fetch cycles.

Function
REQ-014 SHALL define memwait = MemReqM & ~MemReadyM, combinational, so it takes effect in the same cycle.
REQ-015 SHALL define lduse = ResultSrcE0 & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
REQ-016 SHALL, in state RUN with memwait=0, drive StallF = StallD = lduse, FlushD = PCSrcE, FlushE = lduse | PCSrcE, and StallE = StallM = FlushW = 0.
REQ-017 SHALL, whenever memwait=1 or the state is FAULT, drive StallF, StallD, StallE and StallM to 1, FlushW to 1, and FlushD and FlushE to 0; memwait overrides any lduse or PCSrcE flush.
REQ-018 SHALL drive ForwardAE = 2'b10 if RegWriteM & RdM != 0 & RdM == Rs1E, else 2'b01 if RegWriteW & RdW != 0 & RdW == Rs1E, else 2'b00; the M-stage match wins.
REQ-019 SHALL drive ForwardBE by the same rule as ForwardAE, using Rs2E.
REQ-020 SHALL implement the state machine {RUN, WAIT, FAULT} with these transitions:
- RUN -> WAIT when memwait.
- WAIT -> RUN when MemReadyM.
- WAIT -> FAULT when waitcnt == MEM_TIMEOUT - 1 and still memwait.
- FAULT is terminal until reset.
REQ-021 SHALL clear waitcnt (8 bits minimum, wide enough for MEM_TIMEOUT) on entry to WAIT and increment it each WAIT cycle.
REQ-022 SHALL set MemTimeout to 1 on entry to FAULT and hold it until reset.
REQ-023 SHALL increment StallCount on each cycle with StallF=1 and saturate at all-ones.
REQ-024 SHALL stall a PCSrcE that arrives during memwait together with E, and apply its flush in the first cycle after memwait clears.

Reset
REQ-025 SHALL, on reset low, immediately force state=RUN, waitcnt=0, MemTimeout=0 and StallCount=0; registered outputs take these values without waiting for clk.
REQ-026 SHALL, on a reset asserted mid-WAIT or in FAULT, return the block to RUN with no residual stall.

Configuration
REQ-027 SHALL, with HAZ_FORWARD_EN defined, forward operands per REQ-018 and REQ-019.
REQ-028 SHALL, without HAZ_FORWARD_EN, tie ForwardAE and ForwardBE to 2'b00 and extend the lduse term to any RAW dependency: Rs1D or Rs2D equal to a nonzero RdE with RegWriteE, or to a nonzero RdM with RegWriteM.

Structure
REQ-029 SHALL place the state encoding (RUN, WAIT, FAULT) and the forward-select constants (FWD_RF=00, FWD_W=01, FWD_M=10) in the shared pipeline package.
REQ-030 SHALL be a single module; forwarding logic MAY be a sub-module named fwd_unit.

Verification
REQ-031 SHALL check load-use: ResultSrcE0=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for exactly one cycle, and StallCount increments by 1.
REQ-032 SHALL check forward priority: RdM=RdW=Rs1E=7 with RegWriteM=RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01; with Rs1E=0 -> ForwardAE=00.
REQ-033 SHALL check memwait precedence: MemReqM=1, MemReadyM=0 for 3 cycles while PCSrcE=1 -> all stalls=1, FlushE=0, state WAIT; then MemReadyM=1 -> FlushD=FlushE=1 in the next cycle.
REQ-034 SHALL check timeout: MEM_TIMEOUT=4 and MemReadyM held at 0 -> MemTimeout=1 after 4 WAIT cycles; stalls persist while memwait is low; MemTimeout clears only on reset.
REQ-035 SHALL check saturation and reset: CNT_W=4 with 20 stalled cycles -> StallCount=15; async reset asserted mid-WAIT -> StallCount=0, all stalls=0 before the next clk edge.
REQ-036 SHALL check the configuration without HAZ_FORWARD_EN: RegWriteM=1, RdM=3, Rs2D=3 -> StallD=1 and ForwardBE=00.
